// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch front end. It issues one word fetch at a time to the
//   instruction memory and buffers returned words in a 2-entry FIFO of
//   {pc, instr}. It presents the FIFO head to decode and inserts a NOP bubble
//   when the FIFO is empty. A downstream redirect flushes the buffer and
//   restarts fetching at redirect_pc. A response that is still in flight when
//   a redirect arrives is killed.
//
// Parameters
//   RESET_PC        first fetch address after reset
//   NOP_INSTR       instruction word shown while no valid instruction is held
//
// Ports
//   clk             clock; all state changes on the rising edge
//   rst_n           synchronous active-low reset
//   stall           decode is not consuming; hold the presented instruction
//   redirect_valid  taken branch/jump; flush the buffer and refetch
//   redirect_pc     new fetch address, used as given
//   imem_req_valid  fetch request to instruction memory
//   imem_req_ready  memory accepts the request this cycle
//   imem_addr       request address (current fetch pc)
//   imem_resp_valid response word valid this cycle
//   imem_resp_data  returned instruction word
//   instr           instruction to decode
//   instr_pc        pc of instr (fetch pc while bubbling)
//   bubble          instr is not a real instruction
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_2000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        bubble
);

    // WAIT: one request outstanding, its data is wanted.
    // WAIT_KILL: one request outstanding, its data must be dropped.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT      = 2'd1,
        WAIT_KILL = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];

    logic        req_fire_s;
    logic        resp_push_s;
    logic        pop_s;
    logic        wr_idx_s;

    assign req_fire_s  = imem_req_valid & imem_req_ready;
    // A redirect in the same cycle as the response discards that response.
    assign resp_push_s = (state_q == WAIT) & imem_resp_valid & ~redirect_valid;
    assign pop_s       = (count_q != 2'd0) & ~stall & ~redirect_valid;
    // A push only ever happens with count <= 1, so the tail is head + count[0].
    assign wr_idx_s    = head_q ^ count_q[0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            // A request still in flight must have its data killed; if the
            // response lands in this very cycle there is nothing left to kill.
            if ((state_q != IDLE) && !imem_resp_valid) begin
                state_d = WAIT_KILL;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire_s) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT, WAIT_KILL: begin
                    if (imem_resp_valid) begin
                        state_d = IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic: request handshake and presented instruction
    always_comb begin
        imem_req_valid = rst_n & (state_q == IDLE) & (count_q != 2'd2) & ~redirect_valid;
        imem_addr      = fetch_pc_q;
        if (!rst_n) begin
            instr    = NOP_INSTR;
            instr_pc = RESET_PC;
            bubble   = 1'b1;
        end else if (count_q == 2'd0) begin
            instr    = NOP_INSTR;
            instr_pc = fetch_pc_q;
            bubble   = 1'b1;
        end else begin
            instr    = fifo_instr_q[head_q];
            instr_pc = fifo_pc_q[head_q];
            bubble   = 1'b0;
        end
    end

    // Datapath next-state: fetch pc, outstanding request pc, FIFO occupancy
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            count_d    = 2'd0;
            head_d     = 1'b0;
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            case ({resp_push_s, pop_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (pop_s) begin
                head_d = ~head_q;
            end else begin
                head_d = head_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= 2'd0;
            head_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // FIFO storage; contents are only meaningful below count_q, so no reset
    always_ff @(posedge clk) begin
        if (resp_push_s) begin
            fifo_pc_q[wr_idx_s]    <= req_pc_q;
            fifo_instr_q[wr_idx_s] <= imem_resp_data;
        end else begin
            fifo_pc_q[wr_idx_s]    <= fifo_pc_q[wr_idx_s];
            fifo_instr_q[wr_idx_s] <= fifo_instr_q[wr_idx_s];
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A queue-based model of the fetch buffer
//   (pending request flag, kill flag, fetch pc, FIFO of {pc, instr}) predicts
//   the outputs; one compare process checks them every cycle. Literal checks
//   in the stimulus pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_2000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        bubble;

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .bubble          (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic        m_pend;
    logic        m_kill;
    logic        chk_en;

    // Observed stream of delivered pcs and whether killed data ever showed up
    logic [31:0] dut_log [$];
    logic        seen_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Model advance at a rising edge, using the inputs held during the cycle
    task automatic model_step();
        logic acc;
        if (!rst_n) begin
            m_q.delete();
            m_pc   = RST_PC;
            m_pend = 1'b0;
            m_kill = 1'b0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_pc;
            if (m_pend && !imem_resp_valid) begin
                m_kill = 1'b1;
            end else begin
                m_pend = 1'b0;
                m_kill = 1'b0;
            end
        end else begin
            acc = !m_pend && (m_q.size() < 2) && imem_req_ready;
            if ((m_q.size() > 0) && !stall) begin
                void'(m_q.pop_front());
            end
            if (m_pend && imem_resp_valid) begin
                if (!m_kill) begin
                    m_q.push_back({m_addr, imem_resp_data});
                end
                m_pend = 1'b0;
                m_kill = 1'b0;
            end
            if (acc) begin
                m_pend = 1'b1;
                m_kill = 1'b0;
                m_addr = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_cycle();
        logic        empty;
        logic        e_req;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        empty = !rst_n || (m_q.size() == 0);
        e_req = rst_n && !m_pend && (m_q.size() < 2) && !redirect_valid;
        if (!rst_n) begin
            e_instr = NOP;
            e_pc    = RST_PC;
        end else if (empty) begin
            e_instr = NOP;
            e_pc    = m_pc;
        end else begin
            e_instr = m_q[0][31:0];
            e_pc    = m_q[0][63:32];
        end
        chkb("req_valid", imem_req_valid, e_req);
        chk("imem_addr", imem_addr, m_pc);
        chkb("bubble", bubble, empty);
        chk("instr", instr, e_instr);
        chk("instr_pc", instr_pc, e_pc);
        if (rst_n && !bubble) begin
            if ((instr == 32'hDEAD_BEEF) || (instr == 32'hBAD0_0001) || (instr == 32'hBADB_AD02)) begin
                seen_bad = 1'b1;
            end else begin
                seen_bad = seen_bad;
            end
            if (!stall && !redirect_valid) begin
                dut_log.push_back(instr_pc);
            end
        end
    endtask

    // Compare process: outputs are checked on the falling edge every cycle
    always @(negedge clk) begin
        if (chk_en) compare_cycle();
    end

    // One clock cycle: advance the model at the edge, then apply new inputs
    task automatic cyc(input logic rn, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic rsv, input logic [31:0] rd);
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
        #1;
        rst_n           = rn;
        stall           = st;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_req_ready  = rdy;
        imem_resp_valid = rsv;
        imem_resp_data  = rd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        chk_en = 1'b0; seen_bad = 1'b0;
        m_pc = RST_PC; m_addr = RST_PC; m_pend = 1'b0; m_kill = 1'b0;

        // Reset held
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chkb("rst_req", imem_req_valid, 1'b0);
        chkb("rst_bubble", bubble, 1'b1);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", instr_pc, 32'h0000_2000);
        // Cycle 1: first request
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chkb("c1_req", imem_req_valid, 1'b1);
        chk("c1_addr", imem_addr, 32'h0000_2000);
        chkb("c1_bubble", bubble, 1'b1);
        // Cycle 2: response
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0050_0093);
        chkb("c2_req", imem_req_valid, 1'b0);
        // Cycle 3: visible
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("c3_instr", instr, 32'h0050_0093);
        chk("c3_pc", instr_pc, 32'h0000_2000);
        chkb("c3_bubble", bubble, 1'b0);
        // Streaming
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h00A0_0113);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("c5_pc", instr_pc, 32'h0000_2004);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h00F0_0193);
        // Stall for 5 cycles; buffer fills to 2
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("c7_pc", instr_pc, 32'h0000_2008);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0140_0213);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chkb("full_req", imem_req_valid, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("stall_instr", instr, 32'h00F0_0193);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("stall_pc", instr_pc, 32'h0000_2008);
        // Release and drain in order
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("drain_pc", instr_pc, 32'h0000_200C);
        chk("drain_instr", instr, 32'h0140_0213);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chkb("drain_bubble", bubble, 1'b1);
        chk("drain_fpc", instr_pc, 32'h0000_2010);
        chk("log_len", dut_log.size(), 32'd4);
        if (dut_log.size() == 4) begin
            chk("log0", dut_log[0], 32'h0000_2000);
            chk("log1", dut_log[1], 32'h0000_2004);
            chk("log2", dut_log[2], 32'h0000_2008);
            chk("log3", dut_log[3], 32'h0000_200C);
        end
        // Redirect while waiting; response next cycle is killed
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'd0);
        chkb("redir_req", imem_req_valid, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        chkb("kill_req", imem_req_valid, 1'b0);
        chk("kill_pc", instr_pc, 32'h0000_3000);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chkb("r3_req", imem_req_valid, 1'b1);
        chk("r3_addr", imem_addr, 32'h0000_3000);
        chkb("r3_bubble", bubble, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0513);
        chkb("r3w_bubble", bubble, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("r3_instr", instr, 32'h0000_0513);
        chk("r3_pc", instr_pc, 32'h0000_3000);
        // Redirect coinciding with a response
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_4000, 1'b1, 1'b1, 32'hBAD0_0001);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chkb("r4_req", imem_req_valid, 1'b1);
        chk("r4_addr", imem_addr, 32'h0000_4000);
        chkb("r4_bubble", bubble, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0010_0593);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("r4_pc", instr_pc, 32'h0000_4000);
        // Redirect with stall and a full buffer
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0020_0613);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chkb("r5_bubble", bubble, 1'b1);
        chk("r5_addr", imem_addr, 32'h0000_5000);
        chkb("r5_req", imem_req_valid, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0030_0693);
        // One entry buffered and a request outstanding, then reset
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("r5_pc", instr_pc, 32'h0000_5000);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chkb("mid_rst_req", imem_req_valid, 1'b0);
        chkb("mid_rst_bubble", bubble, 1'b1);
        chk("mid_rst_pc", instr_pc, 32'h0000_2000);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBADB_AD02);
        chkb("post_rst_bubble", bubble, 1'b1);
        chk("post_rst_addr", imem_addr, 32'h0000_2000);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chkb("late_ignored", bubble, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0040_0713);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("rr_instr", instr, 32'h0040_0713);
        chk("rr_pc", instr_pc, 32'h0000_2000);
        // Fetch pc wraps modulo 2^32
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0050_0793);
        chk("wrap_fpc", instr_pc, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_next", imem_addr, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0060_0813);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("wrap2_pc", instr_pc, 32'h0000_0000);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chkb("killed_data_seen", seen_bad, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
